// File: rtl/cache_pkg.sv
// Shared types and constants for the data-cache miss/refill path.
// Holds the sequencer state encoding and the line-base helper.
package cache_pkg;

    localparam int LINE_BYTES = 64;
    localparam int BEAT_W     = 32;
    localparam int BEATS      = LINE_BYTES * 8 / BEAT_W;
    localparam int OFFSET_W   = $clog2(LINE_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_DONE
    } miss_state_t;

    function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned offset_w);
        logic [31:0] mask;
        mask = ~((32'd1 << offset_w) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/dcache_miss_ctl_line_buffer.sv
// Beat-addressable line register: one beat written per cycle, whole line read flat.
// Write lands on the next edge; no backpressure, the writer owns the index.
module line_buffer #(
    parameter int BEATS  = 16,
    parameter int BEAT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(BEATS)-1:0]   idx,
    input  logic [BEAT_W-1:0]          wdata,
    output logic [BEATS*BEAT_W-1:0]    line
);

    logic [BEATS-1:0][BEAT_W-1:0] slots;

    always_ff @(posedge clk) begin
        if (!rst) begin
            slots <= '0;
        end else if (we) begin
            slots[idx] <= wdata;
        end
    end

    assign line = slots;

endmodule

// File: rtl/dcache_miss_ctl.sv
// Miss sequencer: optional dirty-line writeback, beat-by-beat refill, one-cycle fill pulse.
// Clean miss 2*BEATS+1 cycles, dirty 3*BEATS+1; mem_gnt/mem_rvalid gaps stretch it cycle for cycle.
module dcache_miss_ctl #(
    parameter int LINE_BYTES = cache_pkg::LINE_BYTES,
    parameter int BEAT_W     = cache_pkg::BEAT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cache_miss,
    input  logic [31:0]             miss_addr,
    input  logic                    evict,
    input  logic [31:0]             evict_addr,
    input  logic [LINE_BYTES*8-1:0] evict_data,
    output logic                    stall,
    output logic                    fill_valid,
    output logic [LINE_BYTES*8-1:0] fill_line,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [BEAT_W-1:0]       mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [BEAT_W-1:0]       mem_rdata
);

    import cache_pkg::*;

    localparam int BEATS      = LINE_BYTES * 8 / BEAT_W;
    localparam int OFFSET_W   = $clog2(LINE_BYTES);
    localparam int CNT_W      = $clog2(BEATS);
    localparam int BEAT_BYTES = BEAT_W / 8;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    miss_state_t                  state, state_nxt;
    logic [CNT_W-1:0]             beat, beat_nxt;
    logic [31:0]                  miss_base, evict_base, beat_off;
    logic [BEATS-1:0][BEAT_W-1:0] victim;
    logic                         accept, buf_we;

    line_buffer #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) u_fill_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .idx   (beat),
        .wdata (mem_rdata),
        .line  (fill_line)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            beat       <= '0;
            miss_base  <= '0;
            evict_base <= '0;
            victim     <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            // Everything the cache may change mid-miss is captured once here.
            if (accept) begin
                miss_base  <= line_base(miss_addr, OFFSET_W);
                evict_base <= line_base(evict_addr, OFFSET_W);
                victim     <= evict_data;
            end
        end
    end

    assign beat_off = 32'(beat) * 32'(BEAT_BYTES);
    assign stall    = (state != ST_IDLE) | cache_miss;

    always_comb begin
        state_nxt  = state;
        beat_nxt   = beat;
        accept     = 1'b0;
        buf_we     = 1'b0;
        fill_valid = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            ST_IDLE: begin
                if (cache_miss) begin
                    accept    = 1'b1;
                    beat_nxt  = '0;
                    state_nxt = evict ? ST_WB : ST_RD_REQ;
                end
            end
            ST_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = evict_base + beat_off;
                mem_wdata = victim[beat];
                if (mem_gnt) begin
                    if (beat == LAST_BEAT) begin
                        beat_nxt  = '0;
                        state_nxt = ST_RD_REQ;
                    end else begin
                        beat_nxt = beat + 1'b1;
                    end
                end
            end
            ST_RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = miss_base + beat_off;
                if (mem_gnt) begin
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rvalid) begin
                    buf_we = 1'b1;
                    if (beat == LAST_BEAT) begin
                        beat_nxt  = '0;
                        state_nxt = ST_DONE;
                    end else begin
                        beat_nxt  = beat + 1'b1;
                        state_nxt = ST_RD_REQ;
                    end
                end
            end
            ST_DONE: begin
                fill_valid = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/dcache_miss_ctl.md
# dcache_miss_ctl

Miss/refill sequencer between the `sa_cache` data cache and the single backing-memory port of the `rv32` pipeline. On a data-cache miss it freezes the pipeline, writes back the evicted dirty line if the cache requests it, fetches the missing line beat by beat, and hands the assembled line to the cache. Only one miss is outstanding at a time.

## Interface
- `LINE_BYTES`, 64: cache line size in bytes; power of two, ≥ 8.
- `BEAT_W`, 32: memory beat width in bits.
- `BEATS`, `LINE_BYTES*8/BEAT_W` (local): beats per line, 16 by default.
- `clk` in 1: system clock.
- `rst` in 1: reset; synchronous, active-low.
- `cache_miss` in 1: the cache has a miss. Held high until `fill_valid` is seen.
- `miss_addr` in 32: address of the missing line. Only bits [31:log2(LINE_BYTES)] are used.
- `evict` in 1: the victim line is dirty. Sampled together with `cache_miss`.
- `evict_addr` in 32: line address of the victim.
- `evict_data` in `LINE_BYTES*8`: victim line contents. Beat 0 is in the LSBs.
- `stall` out 1: freezes every pipeline stage register.
- `fill_valid` out 1: one-cycle pulse; `fill_line` is valid in that cycle.
- `fill_line` out `LINE_BYTES*8`: the fetched line. Beat 0 is in the LSBs.
- `mem_req` out 1: beat request.
- `mem_we` out 1: 1 = write beat, 0 = read beat.
- `mem_addr` out 32: byte address of the beat.
- `mem_wdata` out `BEAT_W`: write beat data.
- `mem_gnt` in 1: the memory accepts the request in this cycle.
- `mem_rvalid` in 1: read data is returned, in order.
- `mem_rdata` in `BEAT_W`: read beat data.

## Operation
- States: IDLE, WB, RD_REQ, RD_WAIT, DONE.
- IDLE:
  - `cache_miss`=1 with `evict`=1 goes to WB.
  - `cache_miss`=1 with `evict`=0 goes to RD_REQ.
  - On that entry, latch `miss_addr`, `evict_addr` and `evict_data`, and clear the beat counter.
- WB:
  - `mem_req`=1, `mem_we`=1.
  - `mem_addr` = evict line base + beat*`BEAT_W`/8.
  - `mem_wdata` = latched victim beat[beat].
  - On `mem_gnt`, the beat counter increments.
  - On `mem_gnt` for the last beat, clear the counter and go to RD_REQ.
- RD_REQ:
  - `mem_req`=1, `mem_we`=0.
  - `mem_addr` = miss line base + beat*`BEAT_W`/8.
  - On `mem_gnt`, go to RD_WAIT.
- RD_WAIT:
  - `mem_req`=0.
  - On `mem_rvalid`, write `mem_rdata` into line buffer slot [beat] and increment the counter.
  - Go to RD_REQ, or to DONE after the last beat.
- DONE:
  - `fill_valid`=1 for this single cycle.
  - Go to IDLE.
- `stall` = (state≠IDLE) | (state==IDLE & `cache_miss`). The pipeline freezes in the same cycle the miss appears.
- `stall` is still 1 during DONE. It drops in the IDLE cycle that follows, provided `cache_miss` has dropped.
- Address arithmetic is modulo 2^32; the line base has its low log2(`LINE_BYTES`) bits zeroed. The beat counter is log2(`BEATS`) bits and wraps only under control of the FSM.
- `mem_rvalid` outside RD_WAIT is ignored. `mem_gnt` while `mem_req`=0 is ignored.
- Changes to `miss_addr`, `evict` or `evict_data` after acceptance in IDLE have no effect.

## Timing
- Reset (`rst`=0 at a `clk` edge):
  - State goes to IDLE and the beat counter to 0.
  - `stall`=0 (unless `cache_miss`=1), `fill_valid`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `fill_line`=0.
  - A reset mid-transfer abandons the transfer immediately; no further beats are issued.
- Minimum miss latency is measured from IDLE acceptance to the `fill_valid` cycle, with `mem_gnt` always 1 and `mem_rvalid` 1 cycle after grant:
  - clean miss: 2*`BEATS`+1 cycles (33 by default);
  - dirty miss: 3*`BEATS`+1 cycles (49 by default).
- Memory stalls stretch the miss cycle for cycle: `mem_gnt`=0 holds the request with address and data stable; a delayed `mem_rvalid` holds RD_WAIT.
- `fill_line` holds its value until the next fill begins.

## Structure
- A shared package `cache_pkg` holds:
  - the FSM state enum;
  - constants `LINE_BYTES`, `BEAT_W`, `BEATS`, `OFFSET_W`;
  - a function computing the line base.
- One sub-module, `line_buffer`:
  - `BEATS`×`BEAT_W` registers with a beat-indexed write port and a flat line output;
  - used for `fill_line`. The victim latch can reuse it as a second instance.
- All other logic stays in the single FSM module.

## Test plan
- Clean miss, `miss_addr`=0x0000_1234, memory returns data 0xA000_0000+beat, `gnt`=1, `rvalid` after 1 cycle:
  - 16 read beats at 0x1200..0x123C;
  - `fill_valid` 33 cycles after acceptance;
  - `fill_line` beat 15 = 0xA000_000F.
- Dirty miss, `evict_addr`=0x0000_8040, `evict_data` beat i = i:
  - 16 writes at 0x8040..0x807C with data 0..15, then the reads;
  - `fill_valid` at cycle 49;
  - `stall` high throughout.
- Random `mem_gnt` and `mem_rvalid` gaps of 0–5 cycles:
  - request, address and data stay stable while ungranted;
  - the line is assembled correctly;
  - exactly one `fill_valid` pulse.
- Reset (`rst`=0 for 1 cycle) during WB beat 7:
  - the next cycle has `mem_req`=0, state IDLE, `stall`=0 with `cache_miss` low.
  - A re-asserted miss restarts from beat 0.
- `cache_miss` asserted during IDLE:
  - `stall`=1 in the same cycle;
  - stray `mem_rvalid` pulses in RD_REQ or IDLE do not corrupt `fill_line`;
  - `miss_addr` changed after acceptance does not alter the read addresses.
